apb4_cmd_master: RTL and testbench

// Parametrised APB4 requester for the DMA controller. Accepts register-access commands on a

---
 rtl/apb4_cmd_master.sv | 193 +++++++++++++++++++
 tb/tb_apb4_cmd_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_cmd_master.sv
// APB4 requester: buffers register-access commands in a FIFO and runs them as
// SETUP/ACCESS transfers with wait states, a timeout and one response per command.
module apb4_cmd_master #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [2:0]  PROT        = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  pclken,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_W-1:0]     paddr,
  output logic                  pwrite,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  output logic [2:0]            pprot,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  idle
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned PTR_W   = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  cmd_t             mem_q [CMD_DEPTH];
  logic [PTR_W:0]   wptr_q, rptr_q;
  logic             empty, full, push, pop;
  cmd_t             head;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [STRB_W-1:0]  pstrb_q, pstrb_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               pclken_q, pclken_d;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                 (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign cmd_ready = !reset && !full;
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PTR_W-1:0]] <= '{write: cmd_write, addr: cmd_addr,
                                    wdata: cmd_wdata, strb: cmd_strb};
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pop           = 1'b0;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    pclken_d      = (state_q != S_IDLE) || !empty;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty && (!rsp_valid_q || rsp_ready)) begin
          pop       = 1'b1;
          state_d   = S_SETUP;
          wait_d    = '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = head.addr;
          pwrite_d  = head.write;
          pwdata_d  = head.write ? head.wdata : '0;
          pstrb_d   = head.write ? head.strb  : '0;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        if (pready) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
        end else if ((TIMEOUT_CYC != 0) && (wait_q == CNT_W'(TO_LAST))) begin
          state_d       = S_IDLE;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      state_q       <= S_IDLE;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      pclken_q      <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      state_q       <= state_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      pclken_q      <= pclken_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = PROT;
  assign pclken      = pclken_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign idle        = empty && (state_q == S_IDLE) && !rsp_valid_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Scoreboard bench for apb4_cmd_master: planned APB slave behaviour per command,
// expected responses queued at acceptance and checked by an independent monitor.
module tb_apb4_cmd_master;

  localparam int          TO    = 16;
  localparam int          DEPTH = 4;
  localparam logic [2:0]  PROTV = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [12:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        pclken, psel, penable, pwrite, pready, pslverr, idle;
  logic [12:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  always #5 clk = ~clk;

  apb4_cmd_master #(.ADDR_W(13), .DATA_W(32), .CMD_DEPTH(DEPTH),
                    .TIMEOUT_CYC(TO), .PROT(PROTV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .pclken(pclken), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .idle(idle)
  );

  typedef struct {
    logic        write;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    rdy_mode = 1;   // 0: hold off, 1: always ready, 2: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one command; on acceptance record the slave plan and the expected response.
  task automatic send(input logic wr, input logic [12:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int waits, input logic err,
                      input logic [31:0] rd);
    plan_t p;
    exp_t  e;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (cmd_ready) begin
        p.write = wr; p.addr = a; p.wdata = wr ? d : 32'h0; p.strb = wr ? s : 4'h0;
        p.waits = waits; p.err = err; p.rdata = rd;
        plan_q.push_back(p);
        e.timeout = (waits >= TO);
        e.err     = e.timeout || err;
        e.rdata   = (!e.timeout && !wr && !err) ? rd : 32'h0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      if (c > 2000) begin
        check("cmd_accept_budget", 64'(c), 64'(0));
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  // APB slave: follows the plan of the transfer at the head of plan_q.
  initial begin : slave
    plan_t cur;
    bit    active = 0;
    int    k = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        active = 0; pready = 1'b0;
      end else if (psel && !penable) begin
        check("setup_after_gap", 64'(active), 64'(0));
        check("pclken_busy", 64'(pclken), 64'(1));
        check("idle_busy", 64'(idle), 64'(0));
        if (plan_q.size() == 0) begin
          check("setup_without_cmd", 64'(1), 64'(0));
        end else begin
          cur = plan_q.pop_front();
          check("setup_paddr", 64'(paddr), 64'(cur.addr));
          check("setup_pwrite", 64'(pwrite), 64'(cur.write));
          check("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
          check("setup_pstrb", 64'(pstrb), 64'(cur.strb));
          check("pprot", 64'(pprot), 64'(PROTV));
          active = 1; k = 0;
        end
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end else if (psel && penable) begin
        if (!active) check("access_without_setup", 64'(1), 64'(0));
        check("access_paddr", 64'(paddr), 64'(cur.addr));
        check("access_pwdata", 64'(pwdata), 64'(cur.wdata));
        check("access_pstrb", 64'(pstrb), 64'(cur.strb));
        check("access_pwrite", 64'(pwrite), 64'(cur.write));
        check("pclken_access", 64'(pclken), 64'(1));
        pready  = (k == cur.waits);
        pslverr = pready ? cur.err : 1'($urandom);
        prdata  = pready ? cur.rdata : $urandom;
        k++;
      end else begin
        check("penable_without_psel", 64'(penable), 64'(0));
        if (active) begin
          check("access_cycles", 64'(k), 64'((cur.waits >= TO) ? TO : cur.waits + 1));
          active = 0;
        end
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end
    end
  end

  initial begin : rsp_drv
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rsp_ready = (rdy_mode == 0) ? 1'b0 :
                  (rdy_mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
        end
      end
    end
  end

  task automatic drain(input string name);
    int c = 0;
    while ((exp_q.size() != 0) && (c < 5000)) begin
      @(posedge clk); c++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int got;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    #23;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_psel", 64'(psel), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_pclken", 64'(pclken), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));
    check("rst_pprot", 64'(pprot), 64'(PROTV));
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Directed cases.
    rdy_mode = 1;
    send(1'b1, 13'h0A4, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    send(1'b0, 13'h010, 32'h5555AAAA, 4'hC, 3, 1'b0, 32'h1234);
    send(1'b0, 13'h1F0, 32'h0, 4'h0, 1000, 1'b0, 32'hFFFF);
    send(1'b1, 13'h044, 32'h01020304, 4'h3, 0, 1'b1, 32'h0);
    send(1'b0, 13'h048, 32'h0, 4'h0, 1, 1'b1, 32'h9999);
    drain("drain_directed");
    check("idle_after_directed", 64'(idle), 64'(1));
    check("pclken_after_directed", 64'(pclken), 64'(0));

    // Fill: one command parks in the response register, DEPTH more fill the FIFO.
    rdy_mode = 0;
    @(posedge clk); #1;
    got = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(1'b1, 13'(16'h100 + i), $urandom, 4'hF, 0, 1'b0, 32'h0);
      got++;
    end
    @(negedge clk);
    check("full_cmd_ready", 64'(cmd_ready), 64'(0));
    check("full_accepted", 64'(got), 64'(DEPTH + 1));
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("full_still_blocked", 64'(cmd_ready), 64'(0));
    check("full_rsp_held", 64'(rsp_valid), 64'(1));
    check("full_not_idle", 64'(idle), 64'(0));
    @(posedge clk); #1;
    rdy_mode = 1;
    drain("drain_full");

    // Reset in ACCESS with two commands still queued.
    send(1'b0, 13'h0C0, 32'h0, 4'h0, 12, 1'b0, 32'hABCD);
    send(1'b1, 13'h0C4, 32'h11, 4'h1, 0, 1'b0, 32'h0);
    send(1'b1, 13'h0C8, 32'h22, 4'h2, 0, 1'b0, 32'h0);
    got = 0;
    while (!(psel && penable) && got < 50) begin
      @(posedge clk); #1; got++;
    end
    check("reached_access", 64'(psel && penable), 64'(1));
    #1 reset = 1'b1;
    #1;
    check("arst_psel", 64'(psel), 64'(0));
    check("arst_penable", 64'(penable), 64'(0));
    check("arst_idle", 64'(idle), 64'(1));
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("post_arst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_arst_psel", 64'(psel), 64'(0));
    check("post_arst_idle", 64'(idle), 64'(1));

    // Randomized traffic.
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(0, 4);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(1'($urandom), 13'($urandom), $urandom, 4'($urandom), w,
           ($urandom_range(0, 5) == 0), $urandom);
    end
    drain("drain_random");
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 64'(idle), 64'(1));
    check("final_pclken", 64'(pclken), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
